ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Host-side driver for the configuration chain (`ccff_head` → … → `ccff_tail`) that threads through the logical tiles. It accepts the bitstream as parallel words over a valid/ready stream and serializes it one bit per enabled `prog_clk` edge into `ccff_head`. It also captures the bits shifted out of `ccff_tail`, which hold the previous configuration, and returns them as readback words. It sits between the configuration port (host, scan controller) and the chain's `prog_clk` gating cell.

## Interface

- `CHAIN_LEN`, 17 — total chain length in bits; 17 is one frac_lut4 tile (16 LUT SRAM bits + 1 mode bit); must be ≥ 1.
- `WORD_W`, 8 — bitstream and readback word width; must be ≥ 2.
- `prog_clk` in 1 — sole clock; all state updates on its rising edge.
- `pReset` in 1 — synchronous, active-high reset.
- `start` in 1 — begin a load; ignored unless in IDLE.
- `cfg_valid` in 1 / `cfg_ready` out 1 / `cfg_data` in WORD_W / `cfg_last` in 1 — bitstream word stream; transfer when valid & ready.
- `ccff_head` out 1 — serial bit into the chain head.
- `ccff_tail` in 1 — serial bit from the chain tail.
- `prog_clk_en` out 1 — chain shifts on a `prog_clk` edge only when this is 1 (drives the ICG).
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out WORD_W — readback word stream.
- `busy` out 1 — high whenever state ≠ IDLE.
- `done` out 1 — single-cycle completion pulse.
- `err` out 1 — sticky framing error; cleared by an accepted `start`.

## Operation

- NWORDS = ceil(CHAIN_LEN / WORD_W). A word's bits are shifted LSB first. The first bit shifted ends at the tail-most chain position. Word-aligned: word w bit i is stream bit w·WORD_W+i.
- Unused bits of the final word are discarded, never shifted. Exactly CHAIN_LEN `prog_clk_en` cycles occur per load.
- States: IDLE, FETCH, SHIFT, DRAIN, DONE.
- IDLE: on `start`, go to FETCH and clear the bit counter, word counter and `err`.
- FETCH: `cfg_ready`=1. On transfer, latch `cfg_data` into the shift register and go to SHIFT.
- Framing check on the transferred word: set `err` if `cfg_last` ≠ (word index == NWORDS−1). Loading continues regardless.
- SHIFT: `ccff_head` = shift register bit 0. `prog_clk_en` = 1 unless stalled.
  - Stall: `rd_valid` & !`rd_ready` forces `prog_clk_en`=0; nothing advances.
  - On each enabled edge: shift the register right, capture `ccff_tail` into readback bit position (bit counter mod WORD_W), increment the bit counter.
  - Readback word complete (WORD_W bits captured, or bit CHAIN_LEN−1 captured): load `rd_data` and set `rd_valid`. Upper bits of a partial final word are 0.
  - After the last bit of a word: go to FETCH if more bits remain, else DRAIN.
- `rd_valid` stays high until `rd_valid` & `rd_ready`. `rd_data` is stable while `rd_valid`=1.
- DRAIN: wait until no readback word is pending, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside SHIFT: `prog_clk_en`=0 and `ccff_head`=0.
- Reset mid-load: the load is aborted and no `done` is produced. Chain contents are undefined; the host must reload.

## Timing

- Reset values: `cfg_ready`, `ccff_head`, `prog_clk_en`, `rd_valid`, `busy`, `done` and `err` are 0. `rd_data` is 0. State is IDLE.
- `start` sampled at edge of cycle 0 → `cfg_ready`=1 in cycle 1.
- Word accepted in cycle k → its bit 0 is on `ccff_head` with `prog_clk_en`=1 in cycle k+1.
- A full word occupies WORD_W enabled cycles, followed by one FETCH bubble cycle.
- `ccff_tail` is sampled on the same edge that shifts the chain, i.e. the tail value before the shift.
- Readback word complete at edge of cycle j → `rd_valid`=1 in cycle j+1.
- `done` asserts the cycle after the final readback handshake; `busy` falls the cycle after `done`.

## Test plan

- Defaults, `cfg_valid`=`rd_ready`=1, start at cycle 0, words 0xA5, 0x3C, 0x01:
  - cfg transfers in cycles 1, 10, 19;
  - `prog_clk_en` high in cycles 2–9, 11–18 and 20 (17 total);
  - `rd_valid` in cycles 10, 19, 21;
  - `done` in cycle 22, `err`=0.
- Chain model pre-loaded with 0x1FFFF, then load 0x00000 → readback words 0xFF, 0xFF, 0x01. Chain now holds the new pattern. A second load returns 0x00, 0x00, 0x00.
- `rd_ready`=0 for 5 cycles while the first readback word is pending → `prog_clk_en`=0 for exactly those cycles. Final chain contents are unchanged versus the unstalled run.
- `cfg_last`=1 on word 1 (of 3) → `err`=1 persists through `done`; the next `start` clears it. `cfg_last` omitted on word 2 → `err`=1.
- `pReset` asserted in cycle 6 of a load → all outputs 0 next cycle, state IDLE, no `done`. Then `start` → `cfg_ready` in the following cycle.
- `start` pulsed while `busy` → no effect. CHAIN_LEN=16, WORD_W=8 → 2 words, no partial readback word, `done` in cycle 20.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream word stream and readback word stream for the chain loader
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_last;
    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;

    // master is the configuration host, slave is the loader
    modport master (
        output cfg_valid, cfg_data, cfg_last, rd_ready,
        input  cfg_ready, rd_valid, rd_data
    );
    modport slave (
        input  cfg_valid, cfg_data, cfg_last, rd_ready,
        output cfg_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words into the ccff chain and returns the old contents
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 17,
    parameter int WORD_W    = 8
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    ccff_chain_loader_if.slave  bus,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                prog_clk_en,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WRD_W  = $clog2(NWORDS + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0] WORD_TOP  = BIT_W'(WORD_W - 1);
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   r_acc;
    logic [WORD_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    r_bit_idx;
    logic [WRD_W-1:0]    r_word_cnt;
    logic                r_err;

    logic                w_stall;
    logic                w_shift_en;
    logic                w_cfg_fire;
    logic                w_rd_fire;
    logic                w_word_end;
    logic                w_chain_end;
    logic                w_is_last_word;
    logic [WORD_W-1:0]   w_acc_next;

    // A pending readback word freezes the chain so no captured tail bit is lost
    assign w_stall        = r_rd_valid & ~bus.rd_ready;
    assign w_shift_en     = (r_state == S_SHIFT) & ~w_stall;
    assign w_cfg_fire     = (r_state == S_FETCH) & bus.cfg_valid;
    assign w_rd_fire      = r_rd_valid & bus.rd_ready;
    assign w_chain_end    = (r_bit_cnt == LAST_BIT);
    assign w_word_end     = (r_bit_idx == WORD_TOP) | w_chain_end;
    assign w_is_last_word = (r_word_cnt == LAST_WORD);

    always_comb begin
        w_acc_next            = r_acc;
        w_acc_next[r_bit_idx] = ccff_tail;
    end

    assign bus.cfg_ready = (r_state == S_FETCH);
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign ccff_head     = (r_state == S_SHIFT) & r_shift[0];
    assign prog_clk_en   = w_shift_en;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_rd_fire) begin
                r_rd_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_bit_cnt  <= '0;
                        r_bit_idx  <= '0;
                        r_word_cnt <= '0;
                        r_acc      <= '0;
                        r_err      <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (w_cfg_fire) begin
                        r_shift    <= bus.cfg_data;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (bus.cfg_last != w_is_last_word) begin
                            r_err <= 1'b1;
                        end
                        r_state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_shift_en) begin
                        r_shift   <= {1'b0, r_shift[WORD_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_word_end) begin
                            // bits beyond the chain end stay 0 because r_acc is cleared per word
                            r_rd_data  <= w_acc_next;
                            r_rd_valid <= 1'b1;
                            r_acc      <= '0;
                            r_bit_idx  <= '0;
                            r_state    <= w_chain_end ? S_DRAIN : S_FETCH;
                        end else begin
                            r_acc     <= w_acc_next;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (!r_rd_valid || bus.rd_ready) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader with a chain model on the tail
module tb_ccff_chain_loader;
    localparam int L  = 17;
    localparam int W  = 8;
    localparam int LB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ccff_chain_loader_if #(.WORD_W(W)) bus_a ();
    ccff_chain_loader_if #(.WORD_W(W)) bus_b ();

    logic start_a = 1'b0, start_b = 1'b0;
    logic head_a, tail_a, en_a, busy_a, done_a, err_a;
    logic head_b, tail_b, en_b, busy_b, done_b, err_b;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut_a (
        .prog_clk(clk), .pReset(rst), .start(start_a), .bus(bus_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .prog_clk_en(en_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
        .prog_clk(clk), .pReset(rst), .start(start_b), .bus(bus_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .prog_clk_en(en_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // chain models: bit 0 is the head position, top bit is the tail
    logic [L-1:0]  chain_a;
    logic [LB-1:0] chain_b;
    logic          preset_a = 1'b0, preset_b = 1'b0;
    logic [L-1:0]  preset_val_a = '0;
    logic [LB-1:0] preset_val_b = '0;

    always @(posedge clk) begin
        if (preset_a)  chain_a <= preset_val_a;
        else if (en_a) chain_a <= {chain_a[L-2:0], head_a};
        if (preset_b)  chain_b <= preset_val_b;
        else if (en_b) chain_b <= {chain_b[LB-2:0], head_b};
    end
    assign tail_a = chain_a[L-1];
    assign tail_b = chain_b[LB-1];

    int checks = 0;
    int failures = 0;

    int           t0;
    bit           mon_on = 1'b0;
    int           nxfer, nen, nrd, ndone, done_cyc;
    logic [63:0]  en_mask, rv_mask;
    int           xfer_cyc [3];
    logic [W-1:0] exp_rd [3];
    logic [W-1:0] got_rd [3];
    logic [L-1:0] stream;
    logic         exp_err;
    logic         prev_rdv, prev_fire;
    logic [W-1:0] prev_rdd;
    logic [L-1:0] chain_saved;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [L-1:0] rev_a(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) r[L-1-i] = v[i];
        return r;
    endfunction

    function automatic logic [LB-1:0] rev_b(input logic [LB-1:0] v);
        logic [LB-1:0] r;
        for (int i = 0; i < LB; i++) r[LB-1-i] = v[i];
        return r;
    endfunction

    task automatic monitor();
        int rel;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                rel = cyc - t0;
                if (bus_a.cfg_ready && bus_a.cfg_valid) begin
                    if (nxfer < 3) xfer_cyc[nxfer] = rel;
                    nxfer++;
                end
                if (en_a) begin
                    if (nen < L) chk(head_a == stream[nen], "head_bit", head_a, stream[nen]);
                    else         chk(1'b0, "extra_enable", nen, L);
                    nen++;
                    if (rel < 64) en_mask[rel] = 1'b1;
                end else if (!(bus_a.rd_valid && !bus_a.rd_ready)) begin
                    chk(head_a == 1'b0, "head_idle", head_a, 0);
                end
                if (bus_a.rd_valid && !bus_a.rd_ready) chk(en_a == 1'b0, "stall_en", en_a, 0);
                if (bus_a.rd_valid) begin
                    if (rel < 64) rv_mask[rel] = 1'b1;
                    if (prev_rdv && !prev_fire) chk(bus_a.rd_data == prev_rdd, "rd_stable", bus_a.rd_data, prev_rdd);
                    if (bus_a.rd_ready) begin
                        if (nrd < 3) begin
                            chk(bus_a.rd_data == exp_rd[nrd], "rd_word", bus_a.rd_data, exp_rd[nrd]);
                            got_rd[nrd] = bus_a.rd_data;
                        end else begin
                            chk(1'b0, "extra_rd", nrd, 3);
                        end
                        nrd++;
                    end
                end
                prev_rdv  = bus_a.rd_valid;
                prev_fire = bus_a.rd_valid && bus_a.rd_ready;
                prev_rdd  = bus_a.rd_data;
                if (done_a) begin
                    ndone++;
                    done_cyc = rel;
                    chk(err_a == exp_err, "err_at_done", err_a, exp_err);
                    chk(nrd == 3, "rd_before_done", nrd, 3);
                    chk(nen == L, "en_total_at_done", nen, L);
                end
            end
        end
    endtask

    // xs >= 0 adds stray start pulses at cycles xs and xs+9 while busy
    task automatic do_load(input logic [W-1:0] w0, w1, w2, input logic [2:0] lastv,
                           input int st0, input int stn, input int xs);
        logic [W-1:0] wd [3];
        int rel;
        int idx;
        wd = '{w0, w1, w2};
        stream = {w2[0], w1, w0};
        exp_rd = '{8'h00, 8'h00, 8'h00};
        for (int n = 0; n < L; n++) exp_rd[n / W][n % W] = chain_a[L-1-n];
        exp_err = (lastv != 3'b100);
        nxfer = 0; nen = 0; nrd = 0; ndone = 0; done_cyc = -1;
        en_mask = '0; rv_mask = '0;
        xfer_cyc = '{-1, -1, -1};
        got_rd = '{8'hxx, 8'hxx, 8'hxx};
        prev_rdv = 1'b0; prev_fire = 1'b0; prev_rdd = '0;
        @(posedge clk); #1;
        t0 = cyc;
        mon_on = 1'b1;
        rel = 0;
        while (ndone == 0 && rel < 100) begin
            idx = (nxfer < 3) ? nxfer : 2;
            bus_a.cfg_valid = 1'b1;
            bus_a.cfg_data  = wd[idx];
            bus_a.cfg_last  = lastv[idx];
            bus_a.rd_ready  = !(rel >= st0 && rel < st0 + stn);
            start_a = (rel == 0) || (xs >= 0 && (rel == xs || rel == xs + 9));
            if (rel == 1) begin
                @(negedge clk);
                chk(bus_a.cfg_ready == 1'b1, "cfg_ready_c1", bus_a.cfg_ready, 1);
                chk(busy_a == 1'b1, "busy_c1", busy_a, 1);
                chk(err_a == 1'b0, "err_cleared_c1", err_a, 0);
            end
            @(posedge clk); #1;
            rel = cyc - t0;
        end
        start_a = 1'b0;
        bus_a.cfg_valid = 1'b0;
        bus_a.rd_ready  = 1'b1;
        chk(ndone == 1, "load_done_seen", ndone, 1);
        @(negedge clk);
        chk(busy_a == 1'b0, "busy_after_done", busy_a, 0);
        chk(done_a == 1'b0, "done_single", done_a, 0);
        mon_on = 1'b0;
        chk(nen == L, "en_total", nen, L);
        chk(nrd == 3, "rd_total", nrd, 3);
        chk(err_a == exp_err, "err_sticky", err_a, exp_err);
        chk(chain_a == rev_a(stream), "chain_loaded", chain_a, rev_a(stream));
    endtask

    task automatic chk_xfer(input int c0, input int c1, input int c2);
        chk(xfer_cyc[0] == c0, "xfer0_cycle", xfer_cyc[0], c0);
        chk(xfer_cyc[1] == c1, "xfer1_cycle", xfer_cyc[1], c1);
        chk(xfer_cyc[2] == c2, "xfer2_cycle", xfer_cyc[2], c2);
    endtask

    task automatic chk_rd(input logic [W-1:0] r0, r1, r2);
        chk(got_rd[0] === r0, "rd_lit0", got_rd[0], r0);
        chk(got_rd[1] === r1, "rd_lit1", got_rd[1], r1);
        chk(got_rd[2] === r2, "rd_lit2", got_rd[2], r2);
    endtask

    initial begin
        int rel, nx, nrb, dcb;
        bus_a.cfg_valid = 1'b0; bus_a.cfg_data = '0; bus_a.cfg_last = 1'b0; bus_a.rd_ready = 1'b1;
        bus_b.cfg_valid = 1'b0; bus_b.cfg_data = '0; bus_b.cfg_last = 1'b0; bus_b.rd_ready = 1'b1;
        fork monitor(); join_none

        preset_val_a = 17'h1FFFF;
        preset_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preset_a = 1'b0;
        @(negedge clk);
        chk(bus_a.cfg_ready == 1'b0, "rst_cfg_ready", bus_a.cfg_ready, 0);
        chk(head_a == 1'b0, "rst_head", head_a, 0);
        chk(en_a == 1'b0, "rst_en", en_a, 0);
        chk(bus_a.rd_valid == 1'b0, "rst_rd_valid", bus_a.rd_valid, 0);
        chk(bus_a.rd_data == '0, "rst_rd_data", bus_a.rd_data, 0);
        chk(busy_a == 1'b0, "rst_busy", busy_a, 0);
        chk(done_a == 1'b0, "rst_done", done_a, 0);
        chk(err_a == 1'b0, "rst_err", err_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_load(8'h00, 8'h00, 8'h00, 3'b100, -1, 0, -1);
        chk_rd(8'hFF, 8'hFF, 8'h01);

        do_load(8'hA5, 8'h3C, 8'h01, 3'b100, -1, 0, -1);
        chk_rd(8'h00, 8'h00, 8'h00);
        chk_xfer(1, 10, 19);
        chk(en_mask == 64'h17FBFC, "en_cycles", en_mask, 64'h17FBFC);
        chk(rv_mask == 64'h280400, "rd_valid_cycles", rv_mask, 64'h280400);
        chk(done_cyc == 22, "done_cycle", done_cyc, 22);
        chain_saved = chain_a;

        do_load(8'h00, 8'h00, 8'h00, 3'b100, -1, 0, -1);
        chk_rd(8'hA5, 8'h3C, 8'h01);

        do_load(8'hA5, 8'h3C, 8'h01, 3'b100, 10, 5, -1);
        chk_xfer(1, 10, 23);
        chk(en_mask == 64'h17F83FC, "stall_en_cycles", en_mask, 64'h17F83FC);
        chk(rv_mask == 64'h280FC00, "stall_rd_valid_cycles", rv_mask, 64'h280FC00);
        chk(done_cyc == 26, "stall_done_cycle", done_cyc, 26);
        chk(chain_a == chain_saved, "stall_chain_same", chain_a, chain_saved);

        do_load(8'h5A, 8'hC3, 8'h00, 3'b110, -1, 0, -1);
        do_load(8'h12, 8'h34, 8'h01, 3'b100, -1, 0, -1);
        do_load(8'h77, 8'h88, 8'h00, 3'b000, -1, 0, -1);

        @(posedge clk); #1;
        t0 = cyc;
        start_a = 1'b1;
        bus_a.cfg_valid = 1'b1; bus_a.cfg_data = 8'hFF; bus_a.cfg_last = 1'b0; bus_a.rd_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.cfg_valid = 1'b0;
        @(negedge clk);
        chk(cyc - t0 == 7, "abort_cycle", cyc - t0, 7);
        chk({bus_a.cfg_ready, head_a, en_a, bus_a.rd_valid, busy_a, done_a, err_a} == 7'b0,
            "abort_outputs", {bus_a.cfg_ready, head_a, en_a, bus_a.rd_valid, busy_a, done_a, err_a}, 0);
        chk(bus_a.rd_data == '0, "abort_rd_data", bus_a.rd_data, 0);
        nx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_a || busy_a) nx++;
        end
        chk(nx == 0, "abort_no_done", nx, 0);

        do_load(8'hA5, 8'h3C, 8'h01, 3'b100, -1, 0, 5);
        chk(done_cyc == 22, "busy_start_done_cycle", done_cyc, 22);
        chk(en_mask == 64'h17FBFC, "busy_start_en_cycles", en_mask, 64'h17FBFC);

        preset_val_b = rev_b(16'h1234);
        preset_b = 1'b1;
        @(posedge clk); #1;
        preset_b = 1'b0;
        t0 = cyc;
        start_b = 1'b1;
        bus_b.cfg_valid = 1'b1;
        bus_b.rd_ready = 1'b1;
        nx = 0; nrb = 0; dcb = -1; rel = 0;
        while (dcb < 0 && rel < 60) begin
            bus_b.cfg_data = (nx == 0) ? 8'h5A : 8'hC3;
            bus_b.cfg_last = (nx == 1);
            @(negedge clk);
            if (bus_b.cfg_ready && bus_b.cfg_valid) nx++;
            if (bus_b.rd_valid) begin
                if (nrb < 2) chk(bus_b.rd_data == ((nrb == 0) ? 8'h34 : 8'h12), "b_rd_word", bus_b.rd_data, (nrb == 0) ? 8'h34 : 8'h12);
                nrb++;
            end
            if (done_b) dcb = rel;
            @(posedge clk); #1;
            start_b = 1'b0;
            rel = cyc - t0;
        end
        bus_b.cfg_valid = 1'b0;
        chk(dcb == 20, "b_done_cycle", dcb, 20);
        chk(nrb == 2, "b_rd_count", nrb, 2);
        chk(err_b == 1'b0, "b_err", err_b, 0);
        chk(chain_b == rev_b(16'hC35A), "b_chain_loaded", chain_b, rev_b(16'hC35A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
